// File: rtl/ula_pkg.sv
// Opcode/funct encoding and FSM state shared by the sequential ALU and its divider step.
package ula_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LOGIC = 6'd1;
    localparam logic [5:0] OP_ADDI  = 6'd2;
    localparam logic [5:0] OP_MOVE  = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_JUMP  = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd6;
    localparam logic [5:0] OP_SW    = 6'd7;
    localparam logic [5:0] OP_LB    = 6'd8;
    localparam logic [5:0] OP_OUT   = 6'd9;
    localparam logic [5:0] OP_BEQ   = 6'd10;
    localparam logic [5:0] OP_BNE   = 6'd11;
    localparam logic [5:0] OP_DIFF  = 6'd13;
    localparam logic [5:0] OP_SBT   = 6'd15;
    localparam logic [5:0] OP_EQUAL = 6'd16;
    localparam logic [5:0] OP_SBTE  = 6'd17;
    localparam logic [5:0] OP_SLTE  = 6'd18;
    localparam logic [5:0] OP_JR    = 6'd19;
    localparam logic [5:0] OP_SUBI  = 6'd20;
    localparam logic [5:0] OP_LWR   = 6'd28;
    localparam logic [5:0] OP_SWR   = 6'd30;
    localparam logic [5:0] OP_LBR   = 6'd31;
    localparam logic [5:0] OP_SB    = 6'd33;

    localparam logic [5:0] F_ADD  = 6'd0;
    localparam logic [5:0] F_SUB  = 6'd1;
    localparam logic [5:0] F_MULT = 6'd2;
    localparam logic [5:0] F_DIV  = 6'd3;
    localparam logic [5:0] F_INC  = 6'd4;
    localparam logic [5:0] F_DEC  = 6'd5;

    localparam logic [5:0] F_AND = 6'd0;
    localparam logic [5:0] F_OR  = 6'd1;
    localparam logic [5:0] F_NOT = 6'd2;
    localparam logic [5:0] F_XOR = 6'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/ula_seq_divisor.sv
// One radix-2 restoring step of the unsigned divider: shifts the next dividend bit
// into the remainder and produces one quotient bit.
module ula_seq_divisor
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remainder,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_remainder,
    output logic [WIDTH-1:0] next_quotient
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // remainder < divisor always holds, so the top diff bit is a clean borrow flag
    always_comb begin
        trial = {remainder, quotient[WIDTH-1]};
        diff  = trial - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            next_remainder = diff[WIDTH-1:0];
            next_quotient  = {quotient[WIDTH-2:0], 1'b1};
        end else begin
            next_remainder = trial[WIDTH-1:0];
            next_quotient  = {quotient[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Multi-cycle ALU with valid/ready handshake; MULT is shift-add, DIV is restoring
// shift-subtract and is only built when ULA_SEQ_DIV_EN is defined.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [5:0]              Opcode,
    input  logic [5:0]              funct,
    input  logic signed [WIDTH-1:0] Dados_1,
    input  logic signed [WIDTH-1:0] Dados_2,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] Resultado,
    output logic                    Zero,
    output logic                    overflow,
    output logic                    div_zero,
    output logic                    busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opa_q, opa_d;
    logic neg_q, neg_d, is_div_q, is_div_d;
    logic signed [WIDTH-1:0] res_q, res_d;
    logic zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, vld_q, vld_d;

    logic signed [WIDTH-1:0] sc_res;
    logic sc_zero, sc_ovf, sc_dz, start_iter, start_div;
    logic [WIDTH-1:0] fix_mag;
    logic accept;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // {overflow, result} of a signed add or subtract
    function automatic logic [WIDTH:0] add_sub(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y,
                                               input logic sub);
        logic signed [WIDTH-1:0] s;
        logic ovf;
        s = sub ? (x - y) : (x + y);
        if (sub) ovf = (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        else     ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return {ovf, s};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign busy      = !in_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_q;
    assign Resultado = res_q;
    assign Zero      = zero_q;
    assign overflow  = ovf_q;
    assign div_zero  = dz_q;

`ifdef ULA_SEQ_DIV_EN
    logic [WIDTH-1:0] div_rem, div_quo;

    ula_seq_divisor #(.WIDTH(WIDTH)) u_divisor (
        .remainder     (acc_q),
        .quotient      (quo_q),
        .divisor       (opa_q),
        .next_remainder(div_rem),
        .next_quotient (div_quo)
    );
`endif

    always_comb begin
        sc_res     = '0;
        sc_zero    = 1'b0;
        sc_ovf     = 1'b0;
        sc_dz      = 1'b0;
        start_iter = 1'b0;
        start_div  = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:  {sc_ovf, sc_res} = add_sub(Dados_1, Dados_2, 1'b0);
                    F_SUB:  {sc_ovf, sc_res} = add_sub(Dados_1, Dados_2, 1'b1);
                    F_INC:  {sc_ovf, sc_res} = add_sub(Dados_1, ONE, 1'b0);
                    F_DEC:  {sc_ovf, sc_res} = add_sub(Dados_1, ONE, 1'b1);
                    F_MULT: start_iter = 1'b1;
`ifdef ULA_SEQ_DIV_EN
                    F_DIV: begin
                        if (Dados_2 == '0) begin
                            sc_dz = 1'b1;
                        end else begin
                            start_iter = 1'b1;
                            start_div  = 1'b1;
                        end
                    end
`else
                    F_DIV:  sc_dz = 1'b1;
`endif
                    default: ;
                endcase
            end
            OP_LOGIC: begin
                case (funct)
                    F_AND:   sc_res = Dados_1 & Dados_2;
                    F_OR:    sc_res = Dados_1 | Dados_2;
                    F_NOT:   sc_res = ~Dados_1;
                    F_XOR:   sc_res = Dados_1 ^ Dados_2;
                    default: ;
                endcase
            end
            OP_ADDI: {sc_ovf, sc_res} = add_sub(Dados_1, Dados_2, 1'b0);
            OP_SUBI: {sc_ovf, sc_res} = add_sub(Dados_1, Dados_2, 1'b1);
            OP_LW, OP_SW, OP_LB, OP_LWR, OP_SWR, OP_LBR, OP_SB: sc_res = Dados_1 + Dados_2;
            OP_MOVE, OP_OUT: sc_res = Dados_1;
            OP_SLT:   sc_res = (Dados_1 <  Dados_2) ? ONE : '0;
            OP_DIFF:  sc_res = (Dados_1 != Dados_2) ? ONE : '0;
            OP_SBT:   sc_res = (Dados_1 >  Dados_2) ? ONE : '0;
            OP_EQUAL: sc_res = (Dados_1 == Dados_2) ? ONE : '0;
            OP_SBTE:  sc_res = (Dados_1 >= Dados_2) ? ONE : '0;
            OP_SLTE:  sc_res = (Dados_1 <= Dados_2) ? ONE : '0;
            OP_JUMP: begin
                sc_res  = Dados_2;
                sc_zero = 1'b1;
            end
            OP_JR:  sc_zero = 1'b1;
            OP_BEQ: sc_zero = (Dados_1 == Dados_2);
            OP_BNE: sc_zero = (Dados_1 != Dados_2);
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        opa_d    = opa_q;
        neg_d    = neg_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        vld_d    = 1'b0;
        fix_mag  = is_div_q ? quo_q : acc_q;
        case (state_q)
            IDLE: begin
                if (accept && start_iter) begin
                    state_d  = ITER;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    acc_d    = '0;
                    quo_d    = mag(Dados_1);
                    opa_d    = mag(Dados_2);
                    neg_d    = Dados_1[WIDTH-1] ^ Dados_2[WIDTH-1];
                    is_div_d = start_div;
                end else if (accept) begin
                    res_d  = sc_res;
                    zero_d = sc_zero;
                    ovf_d  = sc_ovf;
                    dz_d   = sc_dz;
                    vld_d  = 1'b1;
                end
            end
            ITER: begin
                // quo_q holds the multiplier (MSB first) or the dividend being consumed
`ifdef ULA_SEQ_DIV_EN
                if (is_div_q) begin
                    acc_d = div_rem;
                    quo_d = div_quo;
                end else
`endif
                begin
                    acc_d = {acc_q[WIDTH-2:0], 1'b0} + (quo_q[WIDTH-1] ? opa_q : '0);
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                res_d   = neg_q ? (~fix_mag + 1'b1) : fix_mag;
                zero_d  = 1'b0;
                ovf_d   = 1'b0;
                dz_d    = 1'b0;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            opa_q    <= '0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            opa_q    <= opa_d;
            neg_q    <= neg_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, multi-cycle successor to the processor's single-cycle ALU. It keeps the existing Opcode/funct encoding and result/Zero semantics, generalises operand width, and adds a valid/ready handshake. MULT and DIV run on iterative shift-add and shift-subtract datapaths instead of combinational operators. It also adds overflow and divide-by-zero flags. It sits in the execute stage; the control unit stalls while `in_ready` is low.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived; not overridden).

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high only in IDLE; a request is accepted on a rising edge where `in_valid && in_ready`.
- `Opcode`  in  6  operation class; existing encoding.
- `funct`  in  6  sub-operation for Opcode 0 and 1.
- `Dados_1`, `Dados_2`  in  WIDTH  signed operands; sampled only on accept.
- `out_valid`  out  1  one-cycle pulse; result and flags valid.
- `Resultado`  out  WIDTH  signed registered result; held until the next result.
- `Zero`  out  1  branch/jump taken; registered and held.
- `overflow`  out  1  signed overflow for ADD/SUB/ADDI/SUBI/INC/DEC; 0 for all other ops.
- `div_zero`  out  1  DIV with `Dados_2 == 0`.
- `busy`  out  1  iterative operation in flight (`!in_ready`).

## Operation
- **Single-cycle ops** (result registered on the accept edge):
  - ADD, SUB, INC, DEC (Opcode 0, funct 0/1/4/5).
  - AND, OR, NOT, XOR (Opcode 1, funct 0–3).
  - Address adds (Opcode 2, 6, 7, 8, 28, 30, 31, 33).
  - SUBI (20); MOVE/OUT pass `Dados_1` (3, 9).
  - Compares, result zero-extended 1/0: SLT 4, diff 13, sbt 15, equal 16, sbte 17, slte 18.
  - JUMP 5: result `Dados_2`, Zero = 1. JR 19: result 0, Zero = 1.
  - BEQ 10 / BNE 11: result 0, Zero = compare outcome.
  - Undefined Opcode/funct: result 0, Zero = 0, all flags 0.
- **Iterative ops:** MULT (Opcode 0, funct 2) and DIV (Opcode 0, funct 3).
  - Operands are converted to magnitudes on accept; the result sign is restored at the end.
  - MULT returns the low WIDTH bits of the product. No overflow is flagged.
  - DIV truncates toward zero.
  - DIV with `Dados_2 == 0` completes in one cycle: result 0, `div_zero` = 1.
  - DIV of most-negative by -1 returns most-negative. No flag is set.
- **FSM:**
  - IDLE → ITER on accept of MULT/DIV (except divide-by-zero).
  - ITER runs exactly WIDTH cycles, one bit per cycle, counter WIDTH-1 down to 0.
  - ITER → FIX when the counter reaches 0. FIX applies the sign and registers outputs.
  - FIX → IDLE.
- **Handshake:**
  - No back-pressure on the output; `out_valid` is a pulse.
  - `in_valid` while busy is ignored; inputs are not re-sampled.
  - Input changes after accept do not affect the op in flight.
- **Reset, asynchronous, at any time (including mid-ITER):**
  - State IDLE, counter 0, datapath registers 0.
  - `Resultado` 0, `Zero` 0, `overflow` 0, `div_zero` 0, `out_valid` 0.
  - `in_ready` 1, `busy` 0. The in-flight op is discarded.

## Timing
- **Single-cycle op:** accepted at edge N; `out_valid` high and result visible after edge N. Throughput is one op per cycle (back-to-back accepts allowed).
- **MULT/DIV:** accepted at edge N.
  - `busy` is high from after edge N until after edge N+WIDTH+1.
  - `out_valid` pulses after edge N+WIDTH+1, which is also when `in_ready` returns.
  - Latency is WIDTH+1 cycles; 33 at WIDTH=32.
- **Flags:** updated only together with `out_valid`; otherwise held.

## Configuration
- `ULA_SEQ_DIV_EN` defined: iterative divider instantiated; DIV behaves as above.
- Undefined: divider not built. DIV completes as a single-cycle op with result 0 and `div_zero` = 1 regardless of operands. MULT is unaffected.

## Structure
- Shared package `ula_pkg`: Opcode and funct localparams (names per ISA mnemonic) and the FSM state enum (IDLE, ITER, FIX).
- Sub-module `ula_seq_divisor`: radix-2 restoring unsigned divider step.
  - Inputs: remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated under `ULA_SEQ_DIV_EN`.
- The MULT shift-add stays inline.

## Test plan
All scenarios at WIDTH=32.
- Reset mid-MULT (assert at ITER cycle 10) → next cycle `busy` 0, `in_ready` 1, `Resultado` 0, no `out_valid` pulse.
- ADD 0x7FFFFFFF + 1 followed next cycle by SUB 5 - 7 → consecutive `out_valid` pulses; results 0x80000000 with `overflow` 1, then -2 with `overflow` 0.
- MULT -6 × 7 → `out_valid` exactly 33 cycles after accept, result -42; `in_valid` pulsed during busy is ignored.
- DIV -7 / 2 → -3; DIV 100 / 0 → result 0, `div_zero` 1, one-cycle latency; DIV 0x80000000 / -1 → 0x80000000.
- BEQ 5,5 → Zero 1; BNE 5,5 → Zero 0; JUMP with `Dados_2`=0x40 → result 0x40, Zero 1; Opcode 63 → result 0, Zero 0.
- Build without `ULA_SEQ_DIV_EN`: DIV 9 / 3 → result 0, `div_zero` 1, one-cycle latency; MULT 3 × 3 → 9 after 33 cycles.
